// File: rtl/mem_align_unit_if.sv
// Shared widths, memory-type encodings and the MEM-stage/data-memory bus
// seen by the alignment unit.
package mem_align_pkg;
    localparam int DataBusBits    = 64;
    localparam int MemTypeBusBits = 3;
    localparam logic [MemTypeBusBits-1:0] MemTypeB  = 3'd0;
    localparam logic [MemTypeBusBits-1:0] MemTypeH  = 3'd1;
    localparam logic [MemTypeBusBits-1:0] MemTypeW  = 3'd2;
    localparam logic [MemTypeBusBits-1:0] MemTypeD  = 3'd3;
    localparam logic [MemTypeBusBits-1:0] MemTypeBU = 3'd4;
    localparam logic [MemTypeBusBits-1:0] MemTypeHU = 3'd5;
    localparam logic [MemTypeBusBits-1:0] MemTypeWU = 3'd6;
endpackage

interface mem_align_unit_if;
    import mem_align_pkg::*;
    logic                      memRead;
    logic                      memWrite;
    logic [MemTypeBusBits-1:0] memType;
    logic [DataBusBits-1:0]    addr;
    logic [DataBusBits-1:0]    wd;
    logic [DataBusBits-1:0]    rdata;
    logic                      stall;
    logic                      dm_we;
    logic [MemTypeBusBits-1:0] dm_memType;
    logic [DataBusBits-1:0]    dm_addr;
    logic [DataBusBits-1:0]    dm_wd;
    logic [DataBusBits-1:0]    dm_rd;

    modport master (
        output memRead, memWrite, memType, addr, wd, dm_rd,
        input  rdata, stall, dm_we, dm_memType, dm_addr, dm_wd
    );
    modport slave (
        input  memRead, memWrite, memType, addr, wd, dm_rd,
        output rdata, stall, dm_we, dm_memType, dm_addr, dm_wd
    );
endinterface

// File: rtl/mem_align_unit.sv
// Load/store alignment unit: aligned accesses pass through, misaligned ones
// become doubleword reads plus read-modify-write doubleword stores.
module mem_align_unit
    import mem_align_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    mem_align_unit_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, RD1, WR0, WR1, DONE} state_t;

    state_t                    state_q, state_d;
    logic [MemTypeBusBits-1:0] type_q, type_d;
    logic [2:0]                off_q, off_d;
    logic [DataBusBits-1:0]    wd_q, wd_d;
    logic [60:0]               line_q, line_d;
    logic                      store_q, store_d;
    logic                      cross_q, cross_d;
    logic [DataBusBits-1:0]    buf0_q, buf0_d;
    logic [DataBusBits-1:0]    buf1_q, buf1_d;

    function automatic logic [3:0] size_of(input logic [MemTypeBusBits-1:0] t);
        unique case (t)
            MemTypeH, MemTypeHU: size_of = 4'd2;
            MemTypeW, MemTypeWU: size_of = 4'd4;
            MemTypeD:            size_of = 4'd8;
            default:             size_of = 4'd1;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input logic [MemTypeBusBits-1:0] t);
        unique case (t)
            MemTypeH, MemTypeHU: mask_of = 64'h0000_0000_0000_FFFF;
            MemTypeW, MemTypeWU: mask_of = 64'h0000_0000_FFFF_FFFF;
            MemTypeD:            mask_of = '1;
            default:             mask_of = 64'h0000_0000_0000_00FF;
        endcase
    endfunction

    logic [3:0]   in_size;
    logic [2:0]   in_off;
    logic         req;
    logic         misal;
    logic         in_cross;
    logic [63:0]  line0;
    logic [63:0]  line1;
    logic [6:0]   sh;
    logic [127:0] cat;
    logic [127:0] bmask;
    logic [127:0] wshift;
    logic [127:0] merged;
    logic [127:0] lshift;
    logic [63:0]  low;
    logic [63:0]  load_ext;

    always_comb begin
        in_size  = size_of(bus.memType);
        in_off   = bus.addr[2:0];
        req      = bus.memRead | bus.memWrite;
        // size is a power of two, so (size-1) masks off mod size; D gives 3'b111
        misal    = req & ((in_off & (in_size[2:0] - 3'd1)) != 3'd0);
        in_cross = ({1'b0, in_off} + in_size) > 4'd8;
        line0    = {line_q, 3'b000};
        line1    = line0 + 64'd8;
        sh       = {off_q, 3'b000};
        cat      = {buf1_q, buf0_q};
        bmask    = {64'd0, mask_of(type_q)} << sh;
        wshift   = {64'd0, wd_q} << sh;
        merged   = (cat & ~bmask) | (wshift & bmask);
        lshift   = cat >> sh;
        low      = lshift[63:0];
        unique case (type_q)
            MemTypeH:  load_ext = {{48{low[15]}}, low[15:0]};
            MemTypeHU: load_ext = {48'd0, low[15:0]};
            MemTypeW:  load_ext = {{32{low[31]}}, low[31:0]};
            MemTypeWU: load_ext = {32'd0, low[31:0]};
            default:   load_ext = low;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        type_d         = type_q;
        off_d          = off_q;
        wd_d           = wd_q;
        line_d         = line_q;
        store_d        = store_q;
        cross_d        = cross_q;
        buf0_d         = buf0_q;
        buf1_d         = buf1_q;
        bus.stall      = 1'b0;
        bus.dm_we      = bus.memWrite;
        bus.dm_memType = bus.memType;
        bus.dm_addr    = bus.addr;
        bus.dm_wd      = bus.wd;
        bus.rdata      = bus.dm_rd;
        unique case (state_q)
            IDLE: begin
                if (misal) begin
                    bus.stall      = 1'b1;
                    bus.dm_we      = 1'b0;
                    bus.dm_memType = MemTypeD;
                    bus.dm_addr    = {bus.addr[63:3], 3'b000};
                    buf0_d         = bus.dm_rd;
                    type_d         = bus.memType;
                    off_d          = in_off;
                    wd_d           = bus.wd;
                    line_d         = bus.addr[63:3];
                    store_d        = bus.memWrite;
                    cross_d        = in_cross;
                    if (in_cross)         state_d = RD1;
                    else if (bus.memWrite) state_d = WR0;
                    else                  state_d = DONE;
                end
            end
            RD1: begin
                bus.stall      = 1'b1;
                bus.dm_we      = 1'b0;
                bus.dm_memType = MemTypeD;
                bus.dm_addr    = line1;
                buf1_d         = bus.dm_rd;
                state_d        = store_q ? WR0 : DONE;
            end
            WR0: begin
                bus.stall      = 1'b1;
                bus.dm_we      = 1'b1;
                bus.dm_memType = MemTypeD;
                bus.dm_addr    = line0;
                bus.dm_wd      = merged[63:0];
                state_d        = cross_q ? WR1 : DONE;
            end
            WR1: begin
                bus.stall      = 1'b1;
                bus.dm_we      = 1'b1;
                bus.dm_memType = MemTypeD;
                bus.dm_addr    = line1;
                bus.dm_wd      = merged[127:64];
                state_d        = DONE;
            end
            DONE: begin
                bus.dm_we      = 1'b0;
                bus.dm_memType = MemTypeD;
                bus.dm_addr    = line0;
                bus.rdata      = store_q ? 64'd0 : load_ext;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            state_d   = IDLE;
            type_d    = '0;
            off_d     = '0;
            wd_d      = '0;
            line_d    = '0;
            store_d   = 1'b0;
            cross_d   = 1'b0;
            buf0_d    = '0;
            buf1_d    = '0;
            bus.stall = 1'b0;
            bus.dm_we = 1'b0;
            bus.rdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        type_q  <= type_d;
        off_q   <= off_d;
        wd_q    <= wd_d;
        line_q  <= line_d;
        store_q <= store_d;
        cross_q <= cross_d;
        buf0_q  <= buf0_d;
        buf1_q  <= buf1_d;
    end
endmodule
